// File: rtl/bp_iteration_scheduler.sv
// Sequencing controller for the belief-propagation LDPC decoder datapath.
// Alternates row (check-node) and column (variable-node) phases for up to
// MAX_ITER iterations, strobes the H-storage and sum-vector loads, gathers the
// per-processor done flags and aborts a stalled phase through a watchdog.
// Optional feature: define BP_EARLY_TERMINATION_EN to let CHECK finish early
// when syndrome_zero is asserted.
module bp_iteration_scheduler #(
    parameter int NUM_ROWS       = 3,
    parameter int NUM_COLS       = 6,
    parameter int MAX_ITER       = 10,
    parameter int ITER_W         = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [NUM_ROWS-1:0] done_row_processing,
    input  logic [NUM_COLS-1:0] done_column_processing,
    input  logic                syndrome_zero,
    output logic                start_row_processing,
    output logic                start_column_processing,
    output logic                initialize_parity_check_matrix,
    output logic                load_parity_check_matrix,
    output logic                select_input_to_parity_check_matrix,
    output logic                load_sum_vector,
    output logic [ITER_W-1:0]   iteration_count,
    output logic                busy,
    output logic                done,
    output logic                error_timeout
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_ROW_START = 4'd2,
        S_ROW_WAIT  = 4'd3,
        S_ROW_LOAD  = 4'd4,
        S_COL_START = 4'd5,
        S_COL_WAIT  = 4'd6,
        S_COL_LOAD  = 4'd7,
        S_CHECK     = 4'd8,
        S_FINISH    = 4'd9
    } state_t;

    // Watchdog value seen in the last permitted WAIT cycle.
    localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_t              state_r;
    state_t              state_s;
    logic                timeout_s;
    logic                row_all_s;
    logic                col_all_s;
    logic                blanking_s;
    logic [ITER_W-1:0]   iter_next_s;
    logic [NUM_ROWS-1:0] row_seen_r;
    logic [NUM_COLS-1:0] col_seen_r;
    logic [TO_W-1:0]     wd_r;
    logic [ITER_W-1:0]   iter_r;

    logic                start_row_r;
    logic                start_col_r;
    logic                init_pcm_r;
    logic                load_pcm_r;
    logic                select_r;
    logic                load_sum_r;
    logic                busy_r;
    logic                done_r;
    logic                error_timeout_r;

`ifndef BP_EARLY_TERMINATION_EN
    // Early termination is compiled out, so the syndrome input has no consumer.
    logic unused_syndrome_s;
    assign unused_syndrome_s = syndrome_zero;
`endif

    // Completion terms: a bit counts if it was seen earlier in this phase or is high now.
    always_comb begin
        row_all_s   = &(row_seen_r | done_row_processing);
        col_all_s   = &(col_seen_r | done_column_processing);
        blanking_s  = (wd_r == {TO_W{1'b0}});
        iter_next_s = iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
    end

    // Next-state decode; the watchdog is tested before the done terms so it wins a tie.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_INIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INIT:      state_s = S_ROW_START;
            S_ROW_START: state_s = S_ROW_WAIT;
            S_ROW_WAIT: begin
                if (wd_r == WD_LAST) begin
                    state_s   = S_FINISH;
                    timeout_s = 1'b1;
                end else if (!blanking_s && row_all_s) begin
                    state_s = S_ROW_LOAD;
                end else begin
                    state_s = S_ROW_WAIT;
                end
            end
            S_ROW_LOAD:  state_s = S_COL_START;
            S_COL_START: state_s = S_COL_WAIT;
            S_COL_WAIT: begin
                if (wd_r == WD_LAST) begin
                    state_s   = S_FINISH;
                    timeout_s = 1'b1;
                end else if (!blanking_s && col_all_s) begin
                    state_s = S_COL_LOAD;
                end else begin
                    state_s = S_COL_WAIT;
                end
            end
            S_COL_LOAD:  state_s = S_CHECK;
            S_CHECK: begin
                if (iter_next_s == ITER_MAX) begin
                    state_s = S_FINISH;
`ifdef BP_EARLY_TERMINATION_EN
                end else if (syndrome_zero) begin
                    state_s = S_FINISH;
`endif
                end else begin
                    state_s = S_ROW_START;
                end
            end
            S_FINISH:    state_s = S_IDLE;
            default:     state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Watchdog: counts WAIT cycles, zero elsewhere so each phase starts fresh.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_r <= {TO_W{1'b0}};
        end else if ((state_r == S_ROW_WAIT) || (state_r == S_COL_WAIT)) begin
            wd_r <= wd_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= {TO_W{1'b0}};
        end
    end

    // Seen flags: cleared at the phase kick, accumulate after the blanking cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_seen_r <= {NUM_ROWS{1'b0}};
            col_seen_r <= {NUM_COLS{1'b0}};
        end else begin
            if (state_r == S_ROW_START) begin
                row_seen_r <= {NUM_ROWS{1'b0}};
            end else if ((state_r == S_ROW_WAIT) && !blanking_s) begin
                row_seen_r <= row_seen_r | done_row_processing;
            end else begin
                row_seen_r <= row_seen_r;
            end
            if (state_r == S_COL_START) begin
                col_seen_r <= {NUM_COLS{1'b0}};
            end else if ((state_r == S_COL_WAIT) && !blanking_s) begin
                col_seen_r <= col_seen_r | done_column_processing;
            end else begin
                col_seen_r <= col_seen_r;
            end
        end
    end

    // Iteration counter: cleared by an accepted start, bumped when leaving CHECK.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iter_r <= {ITER_W{1'b0}};
        end else if (state_s == S_INIT) begin
            iter_r <= {ITER_W{1'b0}};
        end else if (state_r == S_CHECK) begin
            iter_r <= iter_next_s;
        end else begin
            iter_r <= iter_r;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_row_r     <= 1'b0;
            start_col_r     <= 1'b0;
            init_pcm_r      <= 1'b0;
            load_pcm_r      <= 1'b0;
            select_r        <= 1'b0;
            load_sum_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            error_timeout_r <= 1'b0;
        end else begin
            start_row_r <= (state_s == S_ROW_START);
            start_col_r <= (state_s == S_COL_START);
            init_pcm_r  <= (state_s == S_INIT);
            load_pcm_r  <= (state_s == S_INIT) || (state_s == S_ROW_LOAD) ||
                           (state_s == S_COL_LOAD);
            load_sum_r  <= (state_s == S_COL_LOAD);
            busy_r      <= (state_s != S_IDLE);
            done_r      <= (state_s == S_FINISH);
            if (state_s == S_ROW_LOAD) begin
                select_r <= 1'b0;
            end else if (state_s == S_COL_LOAD) begin
                select_r <= 1'b1;
            end else begin
                select_r <= select_r;
            end
            if (state_s == S_INIT) begin
                error_timeout_r <= 1'b0;
            end else if (timeout_s) begin
                error_timeout_r <= 1'b1;
            end else begin
                error_timeout_r <= error_timeout_r;
            end
        end
    end

    assign start_row_processing                = start_row_r;
    assign start_column_processing             = start_col_r;
    assign initialize_parity_check_matrix      = init_pcm_r;
    assign load_parity_check_matrix            = load_pcm_r;
    assign select_input_to_parity_check_matrix = select_r;
    assign load_sum_vector                     = load_sum_r;
    assign iteration_count                     = iter_r;
    assign busy                                = busy_r;
    assign done                                = done_r;
    assign error_timeout                       = error_timeout_r;

endmodule
